mem_arbiter: RTL and testbench

Shares the CPU's single memory/IO bus between the CPU core (fetch, load, store, IN, OUT issued by the control state machine) and an external DMA/debug requester. It runs a small arbitration state machine, inserts a programmable number of wait states per access, and returns read data with a one-cycle acknowledge so the requester can stall until its transfer completes. It sits between the CPU datapath and the memory/IO devices.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the CPU request, DMA request and shared memory/IO
// bus signals around mem_arbiter.
//   slave  : arbiter view (takes requests, drives acks/rdata/bus/grant)
//   master : requester/device view (drives requests and bus_rdata)
interface mem_arbiter_if #(
  parameter int ADDR_SIZE = 16,
  parameter int WORD_SIZE = 16
);
  // CPU requester
  logic                 cpu_req;
  logic                 cpu_we;
  logic                 cpu_io;
  logic [ADDR_SIZE-1:0] cpu_addr;
  logic [WORD_SIZE-1:0] cpu_wdata;
  logic [WORD_SIZE-1:0] cpu_rdata;
  logic                 cpu_ack;
  // DMA/debug requester (memory space only)
  logic                 dma_req;
  logic                 dma_we;
  logic [ADDR_SIZE-1:0] dma_addr;
  logic [WORD_SIZE-1:0] dma_wdata;
  logic [WORD_SIZE-1:0] dma_rdata;
  logic                 dma_ack;
  // Shared bus
  logic [ADDR_SIZE-1:0] bus_addr;
  logic [WORD_SIZE-1:0] bus_wdata;
  logic                 bus_we;
  logic                 bus_mem_en;
  logic                 bus_io_en;
  logic [WORD_SIZE-1:0] bus_rdata;
  logic [1:0]           grant;

  modport slave (
    input  cpu_req, cpu_we, cpu_io, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  bus_rdata,
    output cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    output bus_addr, bus_wdata, bus_we, bus_mem_en, bus_io_en, grant
  );

  modport master (
    output cpu_req, cpu_we, cpu_io, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output bus_rdata,
    input  cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    input  bus_addr, bus_wdata, bus_we, bus_mem_en, bus_io_en, grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory/IO bus between the CPU core and a DMA/debug
// requester. IDLE arbitrates, ACCESS drives the bus for WAIT_STATES+1 cycles,
// DONE pulses the winner's one-cycle ack. A starvation counter lets a waiting
// DMA request win a tie after DMA_MAX_WAIT consecutive CPU grants.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   arb     : mem_arbiter_if.slave (requests, acks, rdata, bus drive, grant)
module mem_arbiter #(
  parameter int ADDR_SIZE    = 16,
  parameter int WORD_SIZE    = 16,
  parameter int WAIT_STATES  = 1,
  parameter int DMA_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  arb
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_CPU  = 2'b01;
  localparam logic [1:0] G_DMA  = 2'b10;

  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_STATES);
  localparam logic [3:0] STARVE_MAX = 4'(DMA_MAX_WAIT);

  logic [1:0]           state;
  logic [3:0]           wait_cnt;
  logic [3:0]           dma_starve;

  logic                 pick_dma;
  logic [ADDR_SIZE-1:0] win_addr;
  logic [WORD_SIZE-1:0] win_wdata;
  logic                 win_we;
  logic                 win_io;

  // DMA wins when it is alone, or on a tie once it has waited long enough.
  // With DMA_MAX_WAIT = 0 the counter always equals the limit, so DMA wins ties.
  always_comb begin
    pick_dma  = arb.dma_req && (!arb.cpu_req || (dma_starve == STARVE_MAX));
    win_addr  = pick_dma ? arb.dma_addr  : arb.cpu_addr;
    win_wdata = pick_dma ? arb.dma_wdata : arb.cpu_wdata;
    win_we    = pick_dma ? arb.dma_we    : arb.cpu_we;
    win_io    = !pick_dma && arb.cpu_io;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      dma_starve     <= '0;
      arb.grant      <= G_NONE;
      arb.bus_addr   <= '0;
      arb.bus_wdata  <= '0;
      arb.bus_we     <= 1'b0;
      arb.bus_mem_en <= 1'b0;
      arb.bus_io_en  <= 1'b0;
      arb.cpu_rdata  <= '0;
      arb.dma_rdata  <= '0;
      arb.cpu_ack    <= 1'b0;
      arb.dma_ack    <= 1'b0;
    end else begin
      arb.cpu_ack <= 1'b0;
      arb.dma_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arb.cpu_req || arb.dma_req) begin
            state          <= S_ACCESS;
            wait_cnt       <= WAIT_LOAD;
            arb.bus_addr   <= win_addr;
            arb.bus_wdata  <= win_wdata;
            arb.bus_we     <= win_we;
            arb.bus_mem_en <= !win_io;
            arb.bus_io_en  <= win_io;
            if (pick_dma) begin
              arb.grant  <= G_DMA;
              dma_starve <= '0;
            end else begin
              arb.grant <= G_CPU;
              if (arb.dma_req && (dma_starve < STARVE_MAX))
                dma_starve <= dma_starve + 4'd1;
            end
          end
        end

        S_ACCESS: begin
          if (wait_cnt == '0) begin
            if (!arb.bus_we) begin
              if (arb.grant == G_DMA) arb.dma_rdata <= arb.bus_rdata;
              else                    arb.cpu_rdata <= arb.bus_rdata;
            end
            if (arb.grant == G_DMA) arb.dma_ack <= 1'b1;
            else                    arb.cpu_ack <= 1'b1;
            // bus_we shares the enable window rather than lingering into DONE
            arb.bus_we     <= 1'b0;
            arb.bus_mem_en <= 1'b0;
            arb.bus_io_en  <= 1'b0;
            state          <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_DONE: begin
          state      <= S_IDLE;
          arb.grant  <= G_NONE;
          arb.bus_we <= 1'b0;
        end

        default: begin
          state          <= S_IDLE;
          arb.grant      <= G_NONE;
          arb.bus_we     <= 1'b0;
          arb.bus_mem_en <= 1'b0;
          arb.bus_io_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter.
// dut : WAIT_STATES=1, DMA_MAX_WAIT=4 (reset, single-requester table, starvation)
// dutb: WAIT_STATES=0, DMA_MAX_WAIT=0 (back-to-back DMA, DMA always wins ties)
module tb_mem_arbiter;

  localparam int WS = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_SIZE(16), .WORD_SIZE(16)) a ();
  mem_arbiter_if #(.ADDR_SIZE(16), .WORD_SIZE(16)) b ();

  mem_arbiter #(.ADDR_SIZE(16), .WORD_SIZE(16), .WAIT_STATES(1), .DMA_MAX_WAIT(4))
    dut (.clk(clk), .reset_n(reset_n), .arb(a));

  mem_arbiter #(.ADDR_SIZE(16), .WORD_SIZE(16), .WAIT_STATES(0), .DMA_MAX_WAIT(0))
    dutb (.clk(clk), .reset_n(reset_n), .arb(b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          dma;
    bit          we;
    bit          io;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] brd;
    int          exp_mem;
    int          exp_io;
    int          exp_we;
    logic [15:0] exp_cpu_rd;
    logic [15:0] exp_dma_rd;
    logic [1:0]  exp_grant;
  } vec_t;

  vec_t vecs [6];

  // One isolated access on dut; observations at each negedge after the request.
  task automatic run_vec(input vec_t v, input int idx);
    int   en_m = 0, en_i = 0, we_c = 0, other = 0, addr_bad = 0;
    logic ack_ok = 1'b1;
    logic mine;
    logic [1:0] g0 = 2'b00, g_ack = 2'b00, g_end = 2'b11;
    logic [15:0] wd0 = '0;
    logic we_end = 1'b1;
    @(negedge clk);
    if (v.dma) begin
      a.dma_req = 1'b1; a.dma_we = v.we; a.dma_addr = v.addr; a.dma_wdata = v.wdata;
    end else begin
      a.cpu_req = 1'b1; a.cpu_we = v.we; a.cpu_io = v.io; a.cpu_addr = v.addr; a.cpu_wdata = v.wdata;
    end
    a.bus_rdata = v.brd;
    for (int c = 0; c < WS + 3; c++) begin
      @(negedge clk);
      en_m += int'(a.bus_mem_en);
      en_i += int'(a.bus_io_en);
      we_c += int'(a.bus_we);
      mine  = v.dma ? a.dma_ack : a.cpu_ack;
      other += int'(v.dma ? a.cpu_ack : a.dma_ack);
      if (mine !== (c == WS + 1)) ack_ok = 1'b0;
      if ((a.bus_mem_en || a.bus_io_en) && a.bus_addr !== v.addr) addr_bad++;
      if (c == 0) begin g0 = a.grant; wd0 = a.bus_wdata; end
      if (c == WS + 1) begin
        g_ack = a.grant;
        a.cpu_req = 1'b0; a.dma_req = 1'b0;
      end
      if (c == WS + 2) begin g_end = a.grant; we_end = a.bus_we; end
    end
    check($sformatf("v%0d_mem_en_cycles", idx), en_m, v.exp_mem);
    check($sformatf("v%0d_io_en_cycles", idx), en_i, v.exp_io);
    check($sformatf("v%0d_we_cycles", idx), we_c, v.exp_we);
    check($sformatf("v%0d_ack_timing", idx), ack_ok, 1);
    check($sformatf("v%0d_other_ack", idx), other, 0);
    check($sformatf("v%0d_addr_stable", idx), addr_bad, 0);
    check($sformatf("v%0d_wdata", idx), wd0, v.wdata);
    check($sformatf("v%0d_grant_access", idx), g0, v.exp_grant);
    check($sformatf("v%0d_grant_done", idx), g_ack, v.exp_grant);
    check($sformatf("v%0d_grant_idle", idx), {we_end, g_end}, 3'b000);
    check($sformatf("v%0d_cpu_rdata", idx), a.cpu_rdata, v.exp_cpu_rd);
    check($sformatf("v%0d_dma_rdata", idx), a.dma_rdata, v.exp_dma_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_g [6];
    logic [3:0] exp_s [6];
    int en_cnt;
    int t;

    //         dma we io addr      wdata     brd       mem io we cpu_rd    dma_rd    grant
    vecs[0] = '{0, 0, 0, 16'h0040, 16'h0000, 16'hBEEF, 2, 0, 0, 16'hBEEF, 16'h0000, 2'b01};
    vecs[1] = '{0, 1, 1, 16'h0003, 16'h0055, 16'h1234, 0, 2, 2, 16'hBEEF, 16'h0000, 2'b01};
    vecs[2] = '{1, 0, 0, 16'h2000, 16'h0000, 16'hCAFE, 2, 0, 0, 16'hBEEF, 16'hCAFE, 2'b10};
    vecs[3] = '{1, 1, 0, 16'h2001, 16'h7777, 16'h9999, 2, 0, 2, 16'hBEEF, 16'hCAFE, 2'b10};
    vecs[4] = '{0, 0, 1, 16'h0010, 16'h0000, 16'h00A5, 0, 2, 0, 16'h00A5, 16'hCAFE, 2'b01};
    vecs[5] = '{0, 1, 0, 16'hFFFF, 16'hFFFF, 16'h0000, 2, 0, 2, 16'h00A5, 16'hCAFE, 2'b01};

    a.cpu_req = 0; a.cpu_we = 0; a.cpu_io = 0; a.cpu_addr = '0; a.cpu_wdata = '0;
    a.dma_req = 0; a.dma_we = 0; a.dma_addr = '0; a.dma_wdata = '0; a.bus_rdata = '0;
    b.cpu_req = 0; b.cpu_we = 0; b.cpu_io = 0; b.cpu_addr = '0; b.cpu_wdata = '0;
    b.dma_req = 0; b.dma_we = 0; b.dma_addr = '0; b.dma_wdata = '0; b.bus_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_grant", a.grant, 2'b00);
    check("rst_enables_we_acks", {a.bus_mem_en, a.bus_io_en, a.bus_we, a.cpu_ack, a.dma_ack}, 5'b0);
    check("rst_rdata", {a.cpu_rdata, a.dma_rdata}, 32'h0);
    check("rst_bus_addr_wdata", {a.bus_addr, a.bus_wdata}, 32'h0);
    check("rst_starve", dut.dma_starve, 4'd0);
    check("rstb_grant_en", {b.grant, b.bus_mem_en, b.bus_io_en}, 4'b0);
    reset_n = 1'b1;

    // Reset asserted mid-ACCESS
    @(negedge clk);
    a.cpu_req = 1; a.cpu_we = 0; a.cpu_io = 0; a.cpu_addr = 16'h0080; a.bus_rdata = 16'h5A5A;
    @(negedge clk);
    check("rst_mid_pre_en", a.bus_mem_en, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_async", {a.bus_mem_en, a.bus_io_en, a.grant}, 4'b0);
    @(negedge clk);
    check("rst_mid_no_ack1", {a.cpu_ack, a.dma_ack}, 2'b0);
    @(negedge clk);
    check("rst_mid_no_ack2", {a.cpu_ack, a.dma_ack}, 2'b0);
    reset_n = 1'b1;
    en_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      en_cnt += int'(a.bus_mem_en);
      if (c < 2) check($sformatf("rst_rel_no_early_ack%0d", c), a.cpu_ack, 1'b0);
    end
    check("rst_rel_ack", a.cpu_ack, 1'b1);
    check("rst_rel_en_cycles", en_cnt, 2);
    check("rst_rel_rdata", a.cpu_rdata, 16'h5A5A);
    a.cpu_req = 0;
    @(negedge clk);
    check("rst_rel_single_ack", {a.cpu_ack, a.grant}, 3'b0);
    // restore the rdata register to its reset value so the table starts clean
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Single-requester table
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Starvation: both requesting, DMA_MAX_WAIT = 4
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    exp_s = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};
    check("starve_start", dut.dma_starve, 4'd0);
    @(negedge clk);
    a.cpu_we = 0; a.cpu_io = 0; a.cpu_addr = 16'h0100;
    a.dma_we = 0; a.dma_addr = 16'h0200; a.bus_rdata = 16'h0101;
    a.cpu_req = 1; a.dma_req = 1;
    for (int k = 0; k < 6; k++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (a.grant == 2'b00 && t < 20);
      check($sformatf("starve_grant%0d", k), a.grant, exp_g[k]);
      check($sformatf("starve_cnt%0d", k), dut.dma_starve, exp_s[k]);
      t = 0;
      do begin @(negedge clk); t++; end while (!(a.cpu_ack || a.dma_ack) && t < 20);
      check($sformatf("starve_ack%0d", k), {a.cpu_ack, a.dma_ack},
            (exp_g[k] == 2'b10) ? 2'b01 : 2'b10);
      if (k == 5) begin
        a.cpu_req = 0; a.dma_req = 0;
      end else begin
        if (a.cpu_ack) a.cpu_req = 0; else a.dma_req = 0;
        @(negedge clk);
        a.cpu_req = 1; a.dma_req = 1;
      end
    end
    @(negedge clk);
    check("starve_end_idle", a.grant, 2'b00);

    // dutb: WAIT_STATES=0, DMA_MAX_WAIT=0
    @(negedge clk);
    b.cpu_req = 1; b.cpu_we = 0; b.cpu_io = 0; b.cpu_addr = 16'h0300;
    b.dma_req = 1; b.dma_we = 0; b.dma_addr = 16'h1000; b.bus_rdata = 16'h1111;
    @(negedge clk);
    check("b_rd1_grant", b.grant, 2'b10);
    check("b_rd1_bus", {b.bus_mem_en, b.bus_io_en, b.bus_addr}, {2'b10, 16'h1000});
    @(negedge clk);
    check("b_rd1_acks", {b.cpu_ack, b.dma_ack, b.bus_mem_en}, 3'b010);
    check("b_rd1_rdata", b.dma_rdata, 16'h1111);
    b.dma_req = 0;
    @(negedge clk);
    check("b_idle1_grant", b.grant, 2'b00);
    b.dma_req = 1; b.dma_addr = 16'h1001; b.bus_rdata = 16'h2222;
    @(negedge clk);
    check("b_rd2_grant_addr", {b.grant, b.bus_addr}, {2'b10, 16'h1001});
    @(negedge clk);
    check("b_rd2_acks", {b.cpu_ack, b.dma_ack}, 2'b01);
    check("b_rd2_rdata", b.dma_rdata, 16'h2222);
    b.dma_req = 0;
    @(negedge clk);
    check("b_idle2_grant", b.grant, 2'b00);
    b.dma_req = 1; b.dma_we = 1; b.dma_addr = 16'h1002; b.dma_wdata = 16'hABCD;
    @(negedge clk);
    check("b_wr_bus", {b.grant, b.bus_we, b.bus_mem_en, b.bus_wdata}, {4'b1011, 16'hABCD});
    @(negedge clk);
    check("b_wr_acks", {b.cpu_ack, b.dma_ack}, 2'b01);
    check("b_wr_rdata_held", b.dma_rdata, 16'h2222);
    b.dma_req = 0; b.bus_rdata = 16'h3333;
    @(negedge clk);
    check("b_idle3", {b.grant, b.bus_we}, 3'b000);
    @(negedge clk);
    check("b_cpu_grant", {b.grant, b.bus_addr}, {2'b01, 16'h0300});
    @(negedge clk);
    check("b_cpu_ack", {b.cpu_ack, b.dma_ack}, 2'b10);
    check("b_cpu_rdata", b.cpu_rdata, 16'h3333);
    b.cpu_req = 0;
    @(negedge clk);
    check("b_end_idle", b.grant, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
